// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared types and constants for the bit-serial adder.
//   state_t        - controller states IDLE / RUN / DONE (2-bit encoding)
//   DEFAULT_WIDTH  - default operand width
//   cnt_width()    - width of the bit counter for a given operand width
package serial_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    // A counter over WIDTH bit positions needs $clog2(WIDTH) bits;
    // the guard keeps the width at least one bit.
    function automatic int cnt_width(input int width);
        return (width <= 1) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// half_adder / full_adder: one-bit combinational datapath cell for the
// bit-serial adder.
//   half_adder ports: a, b (inputs), sum, carry (outputs)
//   full_adder ports: a, b, cin (inputs), sum, cout (outputs)
// The full adder is built from two half adders plus an OR for the carry.
module half_adder (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);
    assign sum   = a ^ b;
    assign carry = a & b;
endmodule

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    logic s0;
    logic c0;
    logic c1;

    half_adder u_ha0 (.a(a),  .b(b),   .sum(s0),  .carry(c0));
    half_adder u_ha1 (.a(s0), .b(cin), .sum(sum), .carry(c1));

    // The two half-adder carries can never both be 1, so OR is exact.
    assign cout = c0 | c1;
endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder, LSB first, one bit per clock.
//   {carry_o, sum_o} = a_in + b_in + cin_in (unsigned, WIDTH+1 bits).
// Ports:
//   clk_in, rst_n_in          clock, asynchronous active-low reset
//   in_valid_in / in_ready_o  operand handshake (a_in, b_in, cin_in)
//   out_valid_o / out_ready_in result handshake (sum_o, carry_o)
//   overflow_o                signed overflow, only with SERIAL_ADDER_OVF_EN
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1; the producer holds its data stable while valid is 1 and not yet
// accepted, and ready never depends combinationally on valid.
// The controller state is the internal signal 'state' (type state_t).
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             in_valid_in,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin_in,
    output logic             out_valid_o,
    input  logic             out_ready_in,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             overflow_o
`endif
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    // Holds the WIDTH-1 sum bits produced so far; the last bit is taken
    // straight from the full adder on the final edge.
    logic [WIDTH-2:0] res_sr;
    logic             c;
    logic [CW-1:0]    cnt;

    logic             s;
    logic             co;
    logic [WIDTH-1:0] res_next;

    full_adder u_fa (
        .a   (a_sr[0]),
        .b   (b_sr[0]),
        .cin (c),
        .sum (s),
        .cout(co)
    );

    // New sum bit enters at the MSB; after WIDTH shifts the LSB sits at bit 0.
    assign res_next = {s, res_sr};

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state       <= ST_IDLE;
            in_ready_o  <= 1'b1;
            out_valid_o <= 1'b0;
            sum_o       <= '0;
            carry_o     <= 1'b0;
            a_sr        <= '0;
            b_sr        <= '0;
            res_sr      <= '0;
            c           <= 1'b0;
            cnt         <= '0;
`ifdef SERIAL_ADDER_OVF_EN
            overflow_o  <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid_in) begin
                        a_sr       <= a_in;
                        b_sr       <= b_in;
                        c          <= cin_in;
                        res_sr     <= '0;
                        cnt        <= '0;
                        in_ready_o <= 1'b0;
                        state      <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    c      <= co;
                    res_sr <= res_next[WIDTH-1:1];
                    cnt    <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        sum_o       <= res_next;
                        carry_o     <= co;
`ifdef SERIAL_ADDER_OVF_EN
                        // On the MSB edge c is the carry into the MSB.
                        overflow_o  <= c ^ co;
`endif
                        out_valid_o <= 1'b1;
                        state       <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready_in) begin
                        out_valid_o <= 1'b0;
                        in_ready_o  <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid_o <= 1'b0;
                    in_ready_o  <= 1'b1;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed bench for serial_adder (WIDTH=8).
// Expected results come from plain integer addition of the accepted
// operands; a negedge compare process checks every result, its latency,
// output stability and ready/valid exclusivity.
module tb_serial_adder;
    import serial_adder_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic         cin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         carry;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif

    serial_adder #(.WIDTH(W)) dut (
        .clk_in      (clk),
        .rst_n_in    (rst_n),
        .in_valid_in (in_valid),
        .in_ready_o  (in_ready),
        .a_in        (a_in),
        .b_in        (b_in),
        .cin_in      (cin),
        .out_valid_o (out_valid),
        .out_ready_in(out_ready),
        .sum_o       (sum),
        .carry_o     (carry)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .overflow_o  (ovf)
`endif
    );

    // ---------------- clock / cycle count ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad = 0;

    logic [W:0] exp_q[$];
    logic       exp_ov_q[$];
    int         acc_q[$];

    logic       prev_valid = 1'b0;
    logic [W:0] last_cs = '0;
    int         last_acc = 0;
    int         prev_acc = 0;
    int         acc_count = 0;
    int         res_count = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Compare process: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
        end else begin
            check("ready_valid_exclusive", {31'b0, in_ready & out_valid}, 32'd0);
            if (out_valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 32'd1, 32'd0);
                end else begin
                    check("latency", cyc - acc_q[0], W);
                    check("sum_carry", {23'b0, carry, sum}, {23'b0, exp_q[0]});
`ifdef SERIAL_ADDER_OVF_EN
                    check("overflow", {31'b0, ovf}, {31'b0, exp_ov_q[0]});
`endif
                    last_cs = exp_q[0];
                end
            end else begin
                // Outputs hold the last result in DONE and between operations.
                check("held_result", {23'b0, carry, sum}, {23'b0, last_cs});
            end
            if (in_valid && in_ready) begin
                logic [W:0] r;
                r = 9'(a_in) + 9'(b_in) + 9'(cin);
                exp_q.push_back(r);
                exp_ov_q.push_back((a_in[W-1] == b_in[W-1]) && (r[W-1] != a_in[W-1]));
                acc_q.push_back(cyc + 1);
                prev_acc = last_acc;
                last_acc = cyc + 1;
                acc_count++;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() > 0) begin
                    void'(exp_q.pop_front());
                    void'(exp_ov_q.pop_front());
                    void'(acc_q.pop_front());
                end
                res_count++;
            end
            prev_valid = out_valid;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_accept();
        int t;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) check("accept_timeout", 32'd1, 32'd0);
        @(posedge clk);
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                          input logic [W:0] exp_cs, input logic exp_ov, input int hold);
        int t;
        @(posedge clk);
        #1;
        in_valid  = 1'b1;
        a_in      = a;
        b_in      = b;
        cin       = ci;
        out_ready = 1'b0;
        wait_accept();
        #1;
        in_valid = 1'b0;
        a_in     = W'($urandom);
        b_in     = W'($urandom);
        cin      = 1'($urandom);
        t = 0;
        @(negedge clk);
        while (!out_valid && t < 40) begin
            @(negedge clk);
            t++;
        end
        check("result_timeout", {31'b0, out_valid}, 32'd1);
        check("literal_sum_carry", {23'b0, carry, sum}, {23'b0, exp_cs});
`ifdef SERIAL_ADDER_OVF_EN
        check("literal_overflow", {31'b0, ovf}, {31'b0, exp_ov});
`else
        if (exp_ov !== exp_ov) check("ovf_arg_x", 32'd1, 32'd0);
`endif
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("bp_valid_held", {31'b0, out_valid}, 32'd1);
            check("bp_ready_low", {31'b0, in_ready}, 32'd0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check("idle_ready", {31'b0, in_ready}, 32'd1);
        check("idle_valid_low", {31'b0, out_valid}, 32'd0);
    endtask

    task automatic reset_mid_op();
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        a_in     = 8'hAA;
        b_in     = 8'h55;
        cin      = 1'b1;
        wait_accept();
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        exp_q.delete();
        exp_ov_q.delete();
        acc_q.delete();
        last_cs = '0;
        #1;
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_sum_carry", {23'b0, carry, sum}, 32'd0);
        check("rst_state", {30'b0, dut.state}, {30'b0, ST_IDLE});
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic back_to_back();
        int t;
        int n0;
        int r0;
        n0 = acc_count;
        r0 = res_count;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a_in      = 8'h3C;
        b_in      = 8'hC3;
        cin       = 1'b0;
        t = 0;
        while (acc_count < n0 + 1 && t < 40) begin
            @(posedge clk);
            t++;
        end
        // Second operand set appears during the first operation's RUN.
        #1;
        a_in = 8'hC8;
        b_in = 8'h64;
        cin  = 1'b1;
        t = 0;
        while (acc_count < n0 + 2 && t < 40) begin
            @(posedge clk);
            t++;
        end
        #1;
        in_valid = 1'b0;
        a_in     = W'($urandom);
        b_in     = W'($urandom);
        t = 0;
        while (res_count < r0 + 2 && t < 60) begin
            @(negedge clk);
            t++;
        end
        check("b2b_results", res_count - r0, 32'd2);
        check("b2b_spacing", last_acc - prev_acc, W + 2);
        check("b2b_last_result", {23'b0, carry, sum}, {23'b0, 9'h12D});
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        #12;
        check("reset_in_ready", {31'b0, in_ready}, 32'd1);
        check("reset_out_valid", {31'b0, out_valid}, 32'd0);
        check("reset_sum_carry", {23'b0, carry, sum}, 32'd0);
        #11 rst_n = 1'b1;

        run_op(8'h00, 8'h00, 1'b0, 9'h000, 1'b0, 0);
        run_op(8'hFF, 8'h01, 1'b0, 9'h100, 1'b0, 0);
        run_op(8'h7F, 8'h01, 1'b0, 9'h080, 1'b1, 0);
        run_op(8'h12, 8'h34, 1'b1, 9'h047, 1'b0, 5);
        run_op(8'h80, 8'h80, 1'b0, 9'h100, 1'b1, 0);
        run_op(8'hC3, 8'h5A, 1'b1, 9'h11E, 1'b0, 2);

        reset_mid_op();
        run_op(8'hA5, 8'h5A, 1'b1, 9'h100, 1'b0, 0);

        back_to_back();
        run_op(8'h40, 8'h40, 1'b1, 9'h081, 1'b1, 0);

        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
